noc_output_allocator: RTL and testbench

- Per-output-port scheduler for the 5-port mesh router (N, S, E, W, L).
- Each cycle it picks one input port whose head flit targets this output, using round-robin priority. It grants only when the downstream buffer has a free credit.
- Drives the crossbar select, the output-port enable and the winning input's pop.
- The router instantiates one per output port. Edge routers tie the unused requesters to 0.

---
 rtl/noc_pkg.sv | 16 +
 rtl/noc_rr_pick.sv | 31 +++
 rtl/noc_output_allocator.sv | 86 ++++++++
 tb/tb_noc_output_allocator.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared constants and types for the 5-port mesh router.
package noc_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  localparam int NUM_PORTS            = 5;
  localparam int FLIT_W               = 16;
  localparam int DEFAULT_CREDIT_DEPTH = 4;

  typedef logic [2:0] port_sel_t;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module noc_rr_pick
  import noc_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS
) (
  input  logic [NUM_IN-1:0] req,
  input  port_sel_t         ptr,
  output logic [NUM_IN-1:0] grant,
  output port_sel_t         idx,
  output logic              any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = port_sel_t'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_allocator.sv
// Per-output-port round-robin allocator with downstream credit tracking.
// Optional stall statistics counter enabled by macro NOC_ALLOC_STATS_EN.
module noc_output_allocator
  import noc_pkg::*;
#(
  parameter int NUM_IN       = NUM_PORTS,
  parameter int CREDIT_DEPTH = DEFAULT_CREDIT_DEPTH,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req_i,
  input  logic              credit_inc_i,
  output logic [NUM_IN-1:0] grant_o,
  output port_sel_t         port_select_o,
  output logic              port_enable_o,
  output logic [CNT_W-1:0]  credits_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic [15:0]       stall_cnt_o
);

  localparam logic [CNT_W-1:0] FULL_CREDITS = CNT_W'(CREDIT_DEPTH);

  port_sel_t          ptr;
  logic [CNT_W-1:0]   credits;
  logic               overflow;
  logic [NUM_IN-1:0]  pick_grant;
  port_sel_t          pick_idx;
  logic               pick_any;
  logic               credits_zero;
  logic               send;

  noc_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
    .req   (req_i),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Only the registered credit count gates the grant; credit_inc_i never reaches it.
  assign credits_zero  = (credits == '0);
  assign send          = pick_any && !credits_zero && !rst;
  assign grant_o       = send ? pick_grant : '0;
  assign port_select_o = send ? pick_idx : '0;
  assign port_enable_o = send;
  assign credits_o     = credits;
  assign full_o        = credits_zero;
  assign overflow_o    = overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      credits  <= FULL_CREDITS;
      overflow <= 1'b0;
    end else begin
      if (send)
        ptr <= (pick_idx == port_sel_t'(NUM_IN - 1)) ? '0 : pick_idx + 3'd1;
      case ({send, credit_inc_i})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == FULL_CREDITS) overflow <= 1'b1;
          else                         credits  <= credits + 1'b1;
        end
        default: credits <= credits;
      endcase
    end
  end

`ifdef NOC_ALLOC_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if ((req_i != '0) && credits_zero && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_noc_output_allocator.sv
// Directed bench for noc_output_allocator with hand-computed expectations.
module tb_noc_output_allocator;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_i;
  logic        credit_inc_i;
  logic [4:0]  grant_o;
  port_sel_t   port_select_o;
  logic        port_enable_o;
  logic [3:0]  credits_o;
  logic        full_o;
  logic        overflow_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_output_allocator dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .credit_inc_i  (credit_inc_i),
    .grant_o       (grant_o),
    .port_select_o (port_select_o),
    .port_enable_o (port_enable_o),
    .credits_o     (credits_o),
    .full_o        (full_o),
    .overflow_o    (overflow_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs just after an edge, then sample combinational outputs mid-cycle.
  task automatic drive(input logic r, input logic [4:0] q, input logic inc);
    rst = r; req_i = q; credit_inc_i = inc;
    #2;
  endtask

  task automatic chk_grant(input string tag, input logic [4:0] g, input logic [2:0] s,
                           input logic [3:0] c);
    chk({tag, "_grant"}, 32'(grant_o), 32'(g));
    chk({tag, "_sel"},   32'(port_select_o), 32'(s));
    chk({tag, "_en"},    32'(port_enable_o), 32'(g != 5'b0));
    chk({tag, "_cred"},  32'(credits_o), 32'(c));
  endtask

  logic [15:0] exp_stall;

  initial begin
`ifdef NOC_ALLOC_STATS_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd0;
`endif
    rst = 1'b1; req_i = 5'b10110; credit_inc_i = 1'b0;
    tick();
    #2;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_sel",   32'(port_select_o), 32'h0);
    chk("rst_en",    32'(port_enable_o), 32'h0);
    chk("rst_cred",  32'(credits_o), 32'h4);
    chk("rst_ovf",   32'(overflow_o), 32'h0);
    chk("rst_stall", 32'(stall_cnt_o), 32'h0);
    tick();

    // Round robin over S, E, L with credits draining 4..1
    drive(1'b0, 5'b10110, 1'b0); chk_grant("rr0", 5'b00010, 3'd1, 4'd4); tick();
    drive(1'b0, 5'b10110, 1'b0); chk_grant("rr1", 5'b00100, 3'd2, 4'd3); tick();
    drive(1'b0, 5'b10110, 1'b0); chk_grant("rr2", 5'b10000, 3'd4, 4'd2); tick();
    drive(1'b0, 5'b10110, 1'b0); chk_grant("rr3", 5'b00010, 3'd1, 4'd1); tick();

    // Credits exhausted: three stalled cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'b10110, 1'b0);
      chk_grant("stall", 5'b0, 3'd0, 4'd0);
      chk("stall_full", 32'(full_o), 32'h1);
      tick();
    end
    drive(1'b0, 5'b00000, 1'b0);
    chk("stall_cnt", 32'(stall_cnt_o), 32'(exp_stall));

    // Refill to 4 (ptr is 2)
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'b00000, 1'b1); tick();
    end
    drive(1'b0, 5'b00000, 1'b0);
    chk("refill_cred", 32'(credits_o), 32'h4);
    chk("refill_ovf",  32'(overflow_o), 32'h0);

    // W grant moves ptr to 4, then L wins, then wrap to N with simultaneous inc
    drive(1'b0, 5'b01000, 1'b0); chk_grant("w",    5'b01000, 3'd3, 4'd4); tick();
    drive(1'b0, 5'b10001, 1'b0); chk_grant("wrapL", 5'b10000, 3'd4, 4'd3); tick();
    drive(1'b0, 5'b10001, 1'b1); chk_grant("wrapN", 5'b00001, 3'd0, 4'd2); tick();
    drive(1'b0, 5'b00000, 1'b0);
    chk("sendinc_cred", 32'(credits_o), 32'h2);

    // Overflow: inc at full credits
    drive(1'b0, 5'b00000, 1'b1); tick();
    drive(1'b0, 5'b00000, 1'b1); tick();
    drive(1'b0, 5'b00000, 1'b0);
    chk("pre_ovf_cred", 32'(credits_o), 32'h4);
    chk("pre_ovf",      32'(overflow_o), 32'h0);
    drive(1'b0, 5'b00000, 1'b1); tick();
    drive(1'b0, 5'b00000, 1'b0);
    chk("ovf_cred", 32'(credits_o), 32'h4);
    chk("ovf_set",  32'(overflow_o), 32'h1);
    tick();
    chk("ovf_sticky", 32'(overflow_o), 32'h1);

    // Reach credits=1, ptr=3 (ptr currently 1)
    drive(1'b0, 5'b01000, 1'b0); chk_grant("pre_w",  5'b01000, 3'd3, 4'd4); tick();
    drive(1'b0, 5'b00100, 1'b0); chk_grant("pre_e1", 5'b00100, 3'd2, 4'd3); tick();
    drive(1'b0, 5'b00100, 1'b0); chk_grant("pre_e2", 5'b00100, 3'd2, 4'd2); tick();

    // Mid-stream reset
    drive(1'b1, 5'b11111, 1'b0);
    chk_grant("mrst", 5'b0, 3'd0, 4'd1);
    tick();
    drive(1'b1, 5'b11111, 1'b0);
    chk("mrst_cred", 32'(credits_o), 32'h4);
    chk("mrst_ovf",  32'(overflow_o), 32'h0);
    chk("mrst_en",   32'(port_enable_o), 32'h0);
    tick();
    drive(1'b0, 5'b11111, 1'b0); chk_grant("post_rst", 5'b00001, 3'd0, 4'd4); tick();

    // Single requester W wins every cycle until credits run out
    drive(1'b1, 5'b00000, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'b01000, 1'b0);
      chk_grant("single", 5'b01000, 3'd3, 4'(4 - i));
      tick();
    end
    drive(1'b0, 5'b01000, 1'b0);
    chk_grant("single_stop", 5'b0, 3'd0, 4'd0);
    chk("single_full", 32'(full_o), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
